// File: rtl/decode_pkg.sv
// Shared MIPS32 decode definitions: opcode/funct constants, micro-op enum and
// the packed payloads carried between the register-read and decode stages.
package decode_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;
  localparam int unsigned OPC_W = 6;

  // UOP_SLL sits at 0 so a cleared uop reads back as a NOP.
  typedef enum logic [5:0] {
    UOP_SLL, UOP_SRL, UOP_SRA, UOP_SLLV, UOP_SRLV, UOP_SRAV,
    UOP_JR, UOP_JALR, UOP_SYSCALL, UOP_BREAK,
    UOP_MFHI, UOP_MTHI, UOP_MFLO, UOP_MTLO,
    UOP_MULT, UOP_MULTU, UOP_DIV, UOP_DIVU,
    UOP_ADD, UOP_ADDU, UOP_SUB, UOP_SUBU,
    UOP_AND, UOP_OR, UOP_XOR, UOP_NOR, UOP_SLT, UOP_SLTU,
    UOP_ADDI, UOP_ADDIU, UOP_SLTI, UOP_SLTIU,
    UOP_ANDI, UOP_ORI, UOP_XORI, UOP_LUI,
    UOP_BEQ, UOP_BNE, UOP_BLEZ, UOP_BGTZ,
    UOP_BLTZ, UOP_BGEZ, UOP_BLTZAL, UOP_BGEZAL,
    UOP_J, UOP_JAL,
    UOP_LB, UOP_LH, UOP_LW, UOP_LBU, UOP_LHU,
    UOP_SB, UOP_SH, UOP_SW,
    UOP_MFC0, UOP_MTC0, UOP_ERET,
    UOP_RESERVED
  } uop_t;

  localparam uop_t UOP_NOP = UOP_SLL;

  localparam logic [5:0] OPC_SPECIAL = 6'h00;
  localparam logic [5:0] OPC_REGIMM  = 6'h01;
  localparam logic [5:0] OPC_J       = 6'h02;
  localparam logic [5:0] OPC_JAL     = 6'h03;
  localparam logic [5:0] OPC_BEQ     = 6'h04;
  localparam logic [5:0] OPC_BNE     = 6'h05;
  localparam logic [5:0] OPC_BLEZ    = 6'h06;
  localparam logic [5:0] OPC_BGTZ    = 6'h07;
  localparam logic [5:0] OPC_ADDI    = 6'h08;
  localparam logic [5:0] OPC_ADDIU   = 6'h09;
  localparam logic [5:0] OPC_SLTI    = 6'h0A;
  localparam logic [5:0] OPC_SLTIU   = 6'h0B;
  localparam logic [5:0] OPC_ANDI    = 6'h0C;
  localparam logic [5:0] OPC_ORI     = 6'h0D;
  localparam logic [5:0] OPC_XORI    = 6'h0E;
  localparam logic [5:0] OPC_LUI     = 6'h0F;
  localparam logic [5:0] OPC_COP0    = 6'h10;
  localparam logic [5:0] OPC_LB      = 6'h20;
  localparam logic [5:0] OPC_LH      = 6'h21;
  localparam logic [5:0] OPC_LW      = 6'h23;
  localparam logic [5:0] OPC_LBU     = 6'h24;
  localparam logic [5:0] OPC_LHU     = 6'h25;
  localparam logic [5:0] OPC_SB      = 6'h28;
  localparam logic [5:0] OPC_SH      = 6'h29;
  localparam logic [5:0] OPC_SW      = 6'h2B;

  localparam logic [5:0] FN_SLL     = 6'h00;
  localparam logic [5:0] FN_SRL     = 6'h02;
  localparam logic [5:0] FN_SRA     = 6'h03;
  localparam logic [5:0] FN_SLLV    = 6'h04;
  localparam logic [5:0] FN_SRLV    = 6'h06;
  localparam logic [5:0] FN_SRAV    = 6'h07;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_JALR    = 6'h09;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;
  localparam logic [5:0] FN_BREAK   = 6'h0D;
  localparam logic [5:0] FN_MFHI    = 6'h10;
  localparam logic [5:0] FN_MTHI    = 6'h11;
  localparam logic [5:0] FN_MFLO    = 6'h12;
  localparam logic [5:0] FN_MTLO    = 6'h13;
  localparam logic [5:0] FN_MULT    = 6'h18;
  localparam logic [5:0] FN_MULTU   = 6'h19;
  localparam logic [5:0] FN_DIV     = 6'h1A;
  localparam logic [5:0] FN_DIVU    = 6'h1B;
  localparam logic [5:0] FN_ADD     = 6'h20;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUB     = 6'h22;
  localparam logic [5:0] FN_SUBU    = 6'h23;
  localparam logic [5:0] FN_AND     = 6'h24;
  localparam logic [5:0] FN_OR      = 6'h25;
  localparam logic [5:0] FN_XOR     = 6'h26;
  localparam logic [5:0] FN_NOR     = 6'h27;
  localparam logic [5:0] FN_SLT     = 6'h2A;
  localparam logic [5:0] FN_SLTU    = 6'h2B;
  localparam logic [5:0] FN_ERET    = 6'h18;

  localparam logic [4:0] RT_BLTZ    = 5'h00;
  localparam logic [4:0] RT_BGEZ    = 5'h01;
  localparam logic [4:0] RT_BLTZAL  = 5'h10;
  localparam logic [4:0] RT_BGEZAL  = 5'h11;

  localparam logic [4:0] CP0_MF     = 5'h00;
  localparam logic [4:0] CP0_MT     = 5'h04;
  localparam logic [4:0] CP0_CO     = 5'h10;

  localparam logic [4:0] REG_RA     = 5'd31;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic            valid;
  } inst_pkt_t;

  typedef struct packed {
    inst_pkt_t inst;
  } regs_decode_t;

  typedef struct packed {
    logic             valid;
    logic [XLEN-1:0]  pc;
    uop_t             op;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] dst;
    logic             op0_re;
    logic             op1_re;
    logic             dst_we;
    logic [XLEN-1:0]  imm;
    logic             use_imm;
    logic             is_branch;
    logic             is_jump;
    logic             is_ls;
    logic             is_priv;
    logic             reserved;
  } uop_pkt_t;

  typedef struct packed {
    uop_pkt_t uop;
  } decode_regs_t;

  function automatic logic [XLEN-1:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/decode.sv
// MIPS32 instruction decoder: combinational opcode/attribute decode feeding a
// single output register (one-cycle latency, synchronous reset to all-zero).
module decode
  import decode_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  regs_decode_t regs_decode,
  output decode_regs_t decode_regs
);

  logic [XLEN-1:0]  w_inst;
  logic [5:0]       w_opc;
  logic [5:0]       w_funct;
  logic [REG_W-1:0] w_rs;
  logic [REG_W-1:0] w_rt;
  logic [REG_W-1:0] w_rd;
  logic [4:0]       w_shamt;
  logic [15:0]      w_imm16;
  logic [XLEN-1:0]  w_sext;

  uop_t             w_op;
  logic             w_rd_rs;
  logic             w_rd_rt;
  logic             w_wr;
  logic [REG_W-1:0] w_dst;
  logic [XLEN-1:0]  w_imm;
  logic             w_use_imm;
  logic             w_br;
  logic             w_jmp;
  logic             w_ls;
  logic             w_priv;
  logic             w_res;
  uop_pkt_t         w_uop;
  uop_pkt_t         r_uop;

  assign w_inst  = regs_decode.inst.inst;
  assign w_opc   = w_inst[31:26];
  assign w_rs    = w_inst[25:21];
  assign w_rt    = w_inst[20:16];
  assign w_rd    = w_inst[15:11];
  assign w_shamt = w_inst[10:6];
  assign w_funct = w_inst[5:0];
  assign w_imm16 = w_inst[15:0];
  assign w_sext  = sext16(w_imm16);

  // Opcode selection; SPECIAL keys on funct, REGIMM on rt, COP0 on rs.
  always_comb begin
    w_op = UOP_RESERVED;
    case (w_opc)
      OPC_SPECIAL: begin
        case (w_funct)
          FN_SLL:     w_op = UOP_SLL;
          FN_SRL:     w_op = UOP_SRL;
          FN_SRA:     w_op = UOP_SRA;
          FN_SLLV:    w_op = UOP_SLLV;
          FN_SRLV:    w_op = UOP_SRLV;
          FN_SRAV:    w_op = UOP_SRAV;
          FN_JR:      w_op = UOP_JR;
          FN_JALR:    w_op = UOP_JALR;
          FN_SYSCALL: w_op = UOP_SYSCALL;
          FN_BREAK:   w_op = UOP_BREAK;
          FN_MFHI:    w_op = UOP_MFHI;
          FN_MTHI:    w_op = UOP_MTHI;
          FN_MFLO:    w_op = UOP_MFLO;
          FN_MTLO:    w_op = UOP_MTLO;
          FN_MULT:    w_op = UOP_MULT;
          FN_MULTU:   w_op = UOP_MULTU;
          FN_DIV:     w_op = UOP_DIV;
          FN_DIVU:    w_op = UOP_DIVU;
          FN_ADD:     w_op = UOP_ADD;
          FN_ADDU:    w_op = UOP_ADDU;
          FN_SUB:     w_op = UOP_SUB;
          FN_SUBU:    w_op = UOP_SUBU;
          FN_AND:     w_op = UOP_AND;
          FN_OR:      w_op = UOP_OR;
          FN_XOR:     w_op = UOP_XOR;
          FN_NOR:     w_op = UOP_NOR;
          FN_SLT:     w_op = UOP_SLT;
          FN_SLTU:    w_op = UOP_SLTU;
          default:    w_op = UOP_RESERVED;
        endcase
      end
      OPC_REGIMM: begin
        case (w_rt)
          RT_BLTZ:   w_op = UOP_BLTZ;
          RT_BGEZ:   w_op = UOP_BGEZ;
          RT_BLTZAL: w_op = UOP_BLTZAL;
          RT_BGEZAL: w_op = UOP_BGEZAL;
          default:   w_op = UOP_RESERVED;
        endcase
      end
      OPC_COP0: begin
        if (w_rs == CP0_MF)                            w_op = UOP_MFC0;
        else if (w_rs == CP0_MT)                       w_op = UOP_MTC0;
        else if (w_rs == CP0_CO && w_funct == FN_ERET) w_op = UOP_ERET;
        else                                           w_op = UOP_RESERVED;
      end
      OPC_J:     w_op = UOP_J;
      OPC_JAL:   w_op = UOP_JAL;
      OPC_BEQ:   w_op = UOP_BEQ;
      OPC_BNE:   w_op = UOP_BNE;
      OPC_BLEZ:  w_op = UOP_BLEZ;
      OPC_BGTZ:  w_op = UOP_BGTZ;
      OPC_ADDI:  w_op = UOP_ADDI;
      OPC_ADDIU: w_op = UOP_ADDIU;
      OPC_SLTI:  w_op = UOP_SLTI;
      OPC_SLTIU: w_op = UOP_SLTIU;
      OPC_ANDI:  w_op = UOP_ANDI;
      OPC_ORI:   w_op = UOP_ORI;
      OPC_XORI:  w_op = UOP_XORI;
      OPC_LUI:   w_op = UOP_LUI;
      OPC_LB:    w_op = UOP_LB;
      OPC_LH:    w_op = UOP_LH;
      OPC_LW:    w_op = UOP_LW;
      OPC_LBU:   w_op = UOP_LBU;
      OPC_LHU:   w_op = UOP_LHU;
      OPC_SB:    w_op = UOP_SB;
      OPC_SH:    w_op = UOP_SH;
      OPC_SW:    w_op = UOP_SW;
      default:   w_op = UOP_RESERVED;
    endcase
  end

  // Per-op operand usage, destination, immediate form and class flags.
  always_comb begin
    w_rd_rs   = 1'b0;
    w_rd_rt   = 1'b0;
    w_wr      = 1'b0;
    w_dst     = '0;
    w_imm     = '0;
    w_use_imm = 1'b0;
    w_br      = 1'b0;
    w_jmp     = 1'b0;
    w_ls      = 1'b0;
    w_priv    = 1'b0;
    w_res     = 1'b0;
    case (w_op)
      UOP_SLL, UOP_SRL, UOP_SRA: begin
        w_rd_rt = 1'b1; w_wr = 1'b1; w_dst = w_rd;
        w_use_imm = 1'b1; w_imm = XLEN'(w_shamt);
      end
      UOP_SLLV, UOP_SRLV, UOP_SRAV, UOP_ADD, UOP_ADDU, UOP_SUB, UOP_SUBU,
      UOP_AND, UOP_OR, UOP_XOR, UOP_NOR, UOP_SLT, UOP_SLTU: begin
        w_rd_rs = 1'b1; w_rd_rt = 1'b1; w_wr = 1'b1; w_dst = w_rd;
      end
      UOP_JR:   begin w_rd_rs = 1'b1; w_jmp = 1'b1; end
      UOP_JALR: begin w_rd_rs = 1'b1; w_jmp = 1'b1; w_wr = 1'b1; w_dst = w_rd; end
      UOP_MFHI, UOP_MFLO: begin w_wr = 1'b1; w_dst = w_rd; end
      UOP_MTHI, UOP_MTLO: w_rd_rs = 1'b1;
      UOP_MULT, UOP_MULTU, UOP_DIV, UOP_DIVU: begin w_rd_rs = 1'b1; w_rd_rt = 1'b1; end
      UOP_SYSCALL, UOP_BREAK, UOP_ERET: w_priv = 1'b1;
      UOP_ADDI, UOP_ADDIU, UOP_SLTI, UOP_SLTIU: begin
        w_rd_rs = 1'b1; w_wr = 1'b1; w_dst = w_rt; w_use_imm = 1'b1; w_imm = w_sext;
      end
      UOP_ANDI, UOP_ORI, UOP_XORI: begin
        w_rd_rs = 1'b1; w_wr = 1'b1; w_dst = w_rt; w_use_imm = 1'b1; w_imm = XLEN'(w_imm16);
      end
      UOP_LUI: begin w_wr = 1'b1; w_dst = w_rt; w_use_imm = 1'b1; w_imm = {w_imm16, 16'h0000}; end
      UOP_BEQ, UOP_BNE: begin
        w_rd_rs = 1'b1; w_rd_rt = 1'b1; w_br = 1'b1; w_imm = {w_sext[XLEN-3:0], 2'b00};
      end
      UOP_BLEZ, UOP_BGTZ, UOP_BLTZ, UOP_BGEZ: begin
        w_rd_rs = 1'b1; w_br = 1'b1; w_imm = {w_sext[XLEN-3:0], 2'b00};
      end
      UOP_BLTZAL, UOP_BGEZAL: begin
        w_rd_rs = 1'b1; w_br = 1'b1; w_wr = 1'b1; w_dst = REG_RA;
        w_imm = {w_sext[XLEN-3:0], 2'b00};
      end
      UOP_J:   begin w_jmp = 1'b1; w_imm = {4'b0000, w_inst[25:0], 2'b00}; end
      UOP_JAL: begin
        w_jmp = 1'b1; w_wr = 1'b1; w_dst = REG_RA; w_imm = {4'b0000, w_inst[25:0], 2'b00};
      end
      UOP_LB, UOP_LH, UOP_LW, UOP_LBU, UOP_LHU: begin
        w_rd_rs = 1'b1; w_wr = 1'b1; w_dst = w_rt; w_ls = 1'b1; w_imm = w_sext;
      end
      UOP_SB, UOP_SH, UOP_SW: begin
        w_rd_rs = 1'b1; w_rd_rt = 1'b1; w_ls = 1'b1; w_imm = w_sext;
      end
      UOP_MFC0: begin w_wr = 1'b1; w_dst = w_rt; w_priv = 1'b1; end
      UOP_MTC0: begin w_rd_rt = 1'b1; w_priv = 1'b1; end
      default:  w_res = 1'b1;
    endcase
  end

  // An empty slot keeps its decoded fields but may not enable anything downstream.
  always_comb begin
    w_uop       = '0;
    w_uop.valid = regs_decode.inst.valid;
    w_uop.pc    = regs_decode.inst.pc;
    w_uop.op    = w_op;
    w_uop.rs    = w_rs;
    w_uop.rt    = w_rt;
    w_uop.dst   = w_dst;
    w_uop.imm   = w_imm;
    if (regs_decode.inst.valid) begin
      w_uop.op0_re    = w_rd_rs;
      w_uop.op1_re    = w_rd_rt;
      w_uop.dst_we    = w_wr && (w_dst != '0);
      w_uop.use_imm   = w_use_imm;
      w_uop.is_branch = w_br;
      w_uop.is_jump   = w_jmp;
      w_uop.is_ls     = w_ls;
      w_uop.is_priv   = w_priv;
      w_uop.reserved  = w_res;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_uop <= '0;
    else     r_uop <= w_uop;
  end

  assign decode_regs.uop = r_uop;

endmodule

// File: tb/tb_decode.sv
// Scoreboard bench for decode: stimulus pushes expected uops, a monitor pops
// and compares one registered uop per clock.
module tb_decode;
  import decode_pkg::*;

  logic         clk;
  logic         rst;
  regs_decode_t din;
  decode_regs_t dout;

  decode u_dut (
    .clk         (clk),
    .rst         (rst),
    .regs_decode (din),
    .decode_regs (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uop_pkt_t expq[$];
  string    nameq[$];
  int       n_tests = 0;
  int       n_fail  = 0;

  uop_t op_main  [64];
  uop_t op_spec  [64];
  uop_t op_regimm[32];

  // Reference decode: tables give the mnemonic, set membership gives the attributes.
  function automatic uop_pkt_t model(input logic [31:0] w, input logic [31:0] pc, input logic v);
    uop_pkt_t u;
    uop_t op;
    int opc, fn, rsn, rtn, rdn;
    logic [31:0] se;
    logic wr;
    opc = int'(w[31:26]); rsn = int'(w[25:21]); rtn = int'(w[20:16]);
    rdn = int'(w[15:11]); fn = int'(w[5:0]);
    se  = {{16{w[15]}}, w[15:0]};
    if (opc == 0)       op = op_spec[fn];
    else if (opc == 1)  op = op_regimm[rtn];
    else if (opc == 16) op = (rsn == 0) ? UOP_MFC0 : (rsn == 4) ? UOP_MTC0 :
                             (rsn == 16 && fn == 24) ? UOP_ERET : UOP_RESERVED;
    else                op = op_main[opc];
    u = '0;
    u.valid = v; u.pc = pc; u.op = op; u.rs = w[25:21]; u.rt = w[20:16];
    if (op inside {UOP_SLL, UOP_SRL, UOP_SRA, UOP_SLLV, UOP_SRLV, UOP_SRAV, UOP_ADD,
                   UOP_ADDU, UOP_SUB, UOP_SUBU, UOP_AND, UOP_OR, UOP_XOR, UOP_NOR,
                   UOP_SLT, UOP_SLTU, UOP_JALR, UOP_MFHI, UOP_MFLO})
      u.dst = 5'(rdn);
    else if (op inside {UOP_ADDI, UOP_ADDIU, UOP_SLTI, UOP_SLTIU, UOP_ANDI, UOP_ORI,
                        UOP_XORI, UOP_LUI, UOP_LB, UOP_LH, UOP_LW, UOP_LBU, UOP_LHU, UOP_MFC0})
      u.dst = 5'(rtn);
    else if (op inside {UOP_JAL, UOP_BLTZAL, UOP_BGEZAL})
      u.dst = 5'd31;
    wr = (u.dst != 5'd0) || (op inside {UOP_JALR, UOP_MFHI, UOP_MFLO});
    if (op inside {UOP_ADDI, UOP_ADDIU, UOP_SLTI, UOP_SLTIU, UOP_LB, UOP_LH, UOP_LW,
                   UOP_LBU, UOP_LHU, UOP_SB, UOP_SH, UOP_SW})    u.imm = se;
    else if (op inside {UOP_ANDI, UOP_ORI, UOP_XORI})           u.imm = 32'(w[15:0]);
    else if (op == UOP_LUI)                                     u.imm = 32'(w[15:0]) * 32'd65536;
    else if (op inside {UOP_BEQ, UOP_BNE, UOP_BLEZ, UOP_BGTZ, UOP_BLTZ, UOP_BGEZ,
                        UOP_BLTZAL, UOP_BGEZAL})                u.imm = se * 32'd4;
    else if (op inside {UOP_J, UOP_JAL})                        u.imm = 32'(w[25:0]) * 32'd4;
    else if (op inside {UOP_SLL, UOP_SRL, UOP_SRA})             u.imm = 32'(w[10:6]);
    if (v) begin
      u.op0_re = !(op inside {UOP_SLL, UOP_SRL, UOP_SRA, UOP_MFHI, UOP_MFLO, UOP_SYSCALL,
                              UOP_BREAK, UOP_LUI, UOP_J, UOP_JAL, UOP_MFC0, UOP_MTC0,
                              UOP_ERET, UOP_RESERVED});
      u.op1_re = op inside {UOP_SLL, UOP_SRL, UOP_SRA, UOP_SLLV, UOP_SRLV, UOP_SRAV, UOP_ADD,
                            UOP_ADDU, UOP_SUB, UOP_SUBU, UOP_AND, UOP_OR, UOP_XOR, UOP_NOR,
                            UOP_SLT, UOP_SLTU, UOP_MULT, UOP_MULTU, UOP_DIV, UOP_DIVU,
                            UOP_BEQ, UOP_BNE, UOP_SB, UOP_SH, UOP_SW, UOP_MTC0};
      u.dst_we    = wr && (u.dst != 5'd0);
      u.use_imm   = op inside {UOP_ADDI, UOP_ADDIU, UOP_SLTI, UOP_SLTIU, UOP_ANDI, UOP_ORI,
                               UOP_XORI, UOP_LUI, UOP_SLL, UOP_SRL, UOP_SRA};
      u.is_branch = op inside {UOP_BEQ, UOP_BNE, UOP_BLEZ, UOP_BGTZ, UOP_BLTZ, UOP_BGEZ,
                               UOP_BLTZAL, UOP_BGEZAL};
      u.is_jump   = op inside {UOP_J, UOP_JAL, UOP_JR, UOP_JALR};
      u.is_ls     = op inside {UOP_LB, UOP_LH, UOP_LW, UOP_LBU, UOP_LHU, UOP_SB, UOP_SH, UOP_SW};
      u.is_priv   = op inside {UOP_MFC0, UOP_MTC0, UOP_ERET, UOP_SYSCALL, UOP_BREAK};
      u.reserved  = (op == UOP_RESERVED);
    end
    return u;
  endfunction

  // Hand-written expectation; fl = {op0_re,op1_re,dst_we,use_imm,br,jmp,ls,priv,reserved}.
  function automatic uop_pkt_t mk(input logic [31:0] pc, input uop_t op, input logic [4:0] rs,
                                  input logic [4:0] rt, input logic [4:0] dst,
                                  input logic [8:0] fl, input logic [31:0] imm);
    uop_pkt_t u;
    u = '0;
    u.valid = 1'b1; u.pc = pc; u.op = op; u.rs = rs; u.rt = rt; u.dst = dst; u.imm = imm;
    {u.op0_re, u.op1_re, u.dst_we, u.use_imm, u.is_branch, u.is_jump, u.is_ls,
     u.is_priv, u.reserved} = fl;
    return u;
  endfunction

  task automatic step(input logic r, input logic [31:0] w, input logic [31:0] pc,
                      input logic v, input uop_pkt_t e, input string nm);
    uop_pkt_t z;
    z = '0;
    @(negedge clk);
    rst = r;
    din.inst.inst = w; din.inst.pc = pc; din.inst.valid = v;
    expq.push_back(r ? z : e);
    nameq.push_back(nm);
  endtask

  task automatic step_m(input logic r, input logic [31:0] w, input logic [31:0] pc,
                        input logic v, input string nm);
    step(r, w, pc, v, model(w, pc, v), nm);
  endtask

  uop_pkt_t mon_e;
  string    mon_n;
  always @(posedge clk) begin
    #1;
    if (expq.size() > 0) begin
      mon_e = expq.pop_front();
      mon_n = nameq.pop_front();
      n_tests++;
      if (dout.uop !== mon_e) begin
        n_fail++;
        $display("FAIL %s: got %h op=%s required %h op=%s", mon_n, dout.uop,
                 dout.uop.op.name(), mon_e, mon_e.op.name());
      end
    end
  end

  initial begin
    logic [31:0] w, pc;
    logic [5:0]  opcs [22];
    logic [5:0]  fns  [8];
    logic        v, r;
    opcs = '{6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C,
             6'h0D, 6'h0E, 6'h0F, 6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B};
    fns  = '{6'd0, 6'd9, 6'd12, 6'd16, 6'd19, 6'd27, 6'd39, 6'd43};

    for (int i = 0; i < 64; i++) begin op_main[i] = UOP_RESERVED; op_spec[i] = UOP_RESERVED; end
    for (int i = 0; i < 32; i++) op_regimm[i] = UOP_RESERVED;
    op_main[2] = UOP_J;     op_main[3] = UOP_JAL;   op_main[4] = UOP_BEQ;   op_main[5] = UOP_BNE;
    op_main[6] = UOP_BLEZ;  op_main[7] = UOP_BGTZ;  op_main[8] = UOP_ADDI;  op_main[9] = UOP_ADDIU;
    op_main[10] = UOP_SLTI; op_main[11] = UOP_SLTIU; op_main[12] = UOP_ANDI; op_main[13] = UOP_ORI;
    op_main[14] = UOP_XORI; op_main[15] = UOP_LUI;  op_main[32] = UOP_LB;   op_main[33] = UOP_LH;
    op_main[35] = UOP_LW;   op_main[36] = UOP_LBU;  op_main[37] = UOP_LHU;  op_main[40] = UOP_SB;
    op_main[41] = UOP_SH;   op_main[43] = UOP_SW;
    op_spec[0] = UOP_SLL;   op_spec[2] = UOP_SRL;   op_spec[3] = UOP_SRA;   op_spec[4] = UOP_SLLV;
    op_spec[6] = UOP_SRLV;  op_spec[7] = UOP_SRAV;  op_spec[8] = UOP_JR;    op_spec[9] = UOP_JALR;
    op_spec[12] = UOP_SYSCALL; op_spec[13] = UOP_BREAK; op_spec[16] = UOP_MFHI; op_spec[17] = UOP_MTHI;
    op_spec[18] = UOP_MFLO; op_spec[19] = UOP_MTLO; op_spec[24] = UOP_MULT; op_spec[25] = UOP_MULTU;
    op_spec[26] = UOP_DIV;  op_spec[27] = UOP_DIVU; op_spec[32] = UOP_ADD;  op_spec[33] = UOP_ADDU;
    op_spec[34] = UOP_SUB;  op_spec[35] = UOP_SUBU; op_spec[36] = UOP_AND;  op_spec[37] = UOP_OR;
    op_spec[38] = UOP_XOR;  op_spec[39] = UOP_NOR;  op_spec[42] = UOP_SLT;  op_spec[43] = UOP_SLTU;
    op_regimm[0] = UOP_BLTZ; op_regimm[1] = UOP_BGEZ; op_regimm[16] = UOP_BLTZAL; op_regimm[17] = UOP_BGEZAL;

    rst = 1'b1;
    din = '0;
    // Reset held with a live instruction on the input: output must stay zero.
    step(1'b1, 32'h24010005, 32'h0000_0100, 1'b1, '0, "reset_hold");

    step(1'b0, 32'h24010005, 32'h0040_0000, 1'b1,
         mk(32'h0040_0000, UOP_ADDIU, 5'd0, 5'd1, 5'd1, 9'b101100000, 32'h0000_0005), "addiu_r1");
    step(1'b0, 32'h3C02FFFF, 32'h0040_0004, 1'b1,
         mk(32'h0040_0004, UOP_LUI, 5'd0, 5'd2, 5'd2, 9'b001100000, 32'hFFFF_0000), "lui_r2");
    step(1'b0, 32'h00221820, 32'h0040_0008, 1'b1,
         mk(32'h0040_0008, UOP_ADD, 5'd1, 5'd2, 5'd3, 9'b111000000, 32'h0), "add_r3");
    step(1'b0, 32'h8C440004, 32'h0040_000C, 1'b1,
         mk(32'h0040_000C, UOP_LW, 5'd2, 5'd4, 5'd4, 9'b101000100, 32'h0000_0004), "lw_r4");
    step(1'b0, 32'h1022FFFF, 32'h0040_0010, 1'b1,
         mk(32'h0040_0010, UOP_BEQ, 5'd1, 5'd2, 5'd0, 9'b110010000, 32'hFFFF_FFFC), "beq_back");
    step(1'b0, 32'h00000000, 32'h0040_0014, 1'b1,
         mk(32'h0040_0014, UOP_NOP, 5'd0, 5'd0, 5'd0, 9'b010100000, 32'h0), "nop");
    step(1'b0, 32'hFFFFFFFF, 32'h0040_0018, 1'b1,
         mk(32'h0040_0018, UOP_RESERVED, 5'd31, 5'd31, 5'd0, 9'b000000001, 32'h0), "reserved_ones");
    step(1'b0, 32'h24000001, 32'h0040_001C, 1'b1,
         mk(32'h0040_001C, UOP_ADDIU, 5'd0, 5'd0, 5'd0, 9'b100100000, 32'h0000_0001), "addiu_r0");

    // Sequential stream, reset mid-stream, resume, then an empty slot.
    pc = 32'h0040_0020;
    for (int i = 0; i < 4; i++) begin
      step_m(1'b0, 32'h00221820 + 32'(i) * 32'h800, pc, 1'b1, "stream");
      pc += 32'd4;
    end
    step_m(1'b1, 32'h0C100010, pc, 1'b1, "mid_reset");
    pc += 32'd4;
    step_m(1'b0, 32'h0C100010, pc, 1'b1, "jal_resume");
    pc += 32'd4;
    step_m(1'b0, 32'h04110003, pc, 1'b1, "bgezal_resume");
    pc += 32'd4;
    step_m(1'b0, 32'h00221820, pc, 1'b0, "invalid_slot");
    pc += 32'd4;

    for (int i = 0; i < 600; i++) begin
      w = $urandom;
      case ($urandom_range(0, 5))
        0: begin w[31:26] = 6'h00; if ($urandom_range(0, 1) == 1) w[5:0] = fns[$urandom_range(0, 7)]; end
        1: begin w[31:26] = 6'h01; if ($urandom_range(0, 1) == 1) w[20:16] = 5'($urandom_range(0, 1)) | (5'($urandom_range(0, 1)) << 4); end
        2: begin
          w[31:26] = 6'h10;
          case ($urandom_range(0, 3))
            0: w[25:21] = 5'h00;
            1: w[25:21] = 5'h04;
            2: begin w[25:21] = 5'h10; if ($urandom_range(0, 1) == 1) w[5:0] = 6'h18; end
            default: ;
          endcase
        end
        3, 4: w[31:26] = opcs[$urandom_range(0, 21)];
        default: ;
      endcase
      v = ($urandom_range(0, 9) != 0);
      r = ($urandom_range(0, 39) == 0);
      step_m(r, w, pc, v, "random");
      pc += 32'd4;
    end

    @(negedge clk);
    rst = 1'b0;
    din = '0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (expq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending required 0", expq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
